// File: rtl/ram.sv
// Single-port RAM with a post-reset zero-fill sequencer. Define RAM_RDREG_EN
// for a registered, write-first read port; otherwise RAMout is combinational.
module ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] RAMout,
  output logic                  busy
);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    addr_ok;
  logic                    clr_we;
  logic                    usr_we;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign addr_ok = ({1'b0, Address} < DEPTH_W);
  // A reset edge always wins: neither a clear step nor a user write lands on it.
  assign clr_we  = (state_q == CLEAR) && !reset;
  assign usr_we  = (state_q == READY) && !reset && write && addr_ok;
  assign rd_data = addr_ok ? mem[Address] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == CLEAR) begin
      ptr_q <= ptr_q + ADDR_WIDTH'(1);
      if (ptr_q == PTR_LAST) begin
        state_q <= READY;
        busy_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clr_we)      mem[ptr_q]   <= '0;
    else if (usr_we) mem[Address] <= data;
  end

`ifdef RAM_RDREG_EN
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rd_data;
    if (usr_we) rdata_d = data;
    if (busy_q) rdata_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign RAMout = rdata_q;
`else
  assign RAMout = busy_q ? '0 : rd_data;
`endif

  assign busy = busy_q;

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: a word-array model plus hand-computed expectations.
module tb_ram;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int DEPTH = 512;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] Address = '0;
  logic          write = 1'b0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] RAMout;
  logic          busy;

  ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .Address(Address), .write(write),
    .data(data), .RAMout(RAMout), .busy(busy)
  );

  always #5 clock = ~clock;

  // Model: contents, remaining clear cycles, and registered read value.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = 0;
  logic          m_on = 1'b0;
  logic [DW-1:0] m_rd = '0;

  always @(posedge clock) begin
    if (reset) begin
      m_on   <= 1'b1;
      m_left <= DEPTH;
      m_rd   <= '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else if (m_on) begin
      if (m_left != 0) begin
        m_left <= m_left - 1;
        m_rd   <= '0;
      end else begin
        if (write && int'(Address) < DEPTH) m_mem[Address] <= data;
        if (int'(Address) >= DEPTH) m_rd <= '0;
        else if (write)             m_rd <= data;
        else                        m_rd <= m_mem[Address];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  string         lit_name = "";
  logic [DW-1:0] lit_act = '0;
  logic [DW-1:0] lit_exp = '0;
  int            lit_seq = 0;

  // Sole compare process: model vs DUT every cycle, plus queued literal checks.
  initial begin
    int lit_seen;
    logic [DW-1:0] exp_out;
    lit_seen = 0;
    forever begin
      @(negedge clock);
      if (m_on) begin
`ifdef RAM_RDREG_EN
        exp_out = m_rd;
`else
        exp_out = (m_left != 0 || int'(Address) >= DEPTH) ? '0 : m_mem[Address];
`endif
        checks++;
        if (busy !== (m_left != 0)) begin
          failures++;
          $display("FAIL busy t=%0t got=%b want=%b", $time, busy, (m_left != 0));
        end
        checks++;
        if (RAMout !== exp_out) begin
          failures++;
          $display("FAIL RAMout t=%0t addr=%0d got=%h want=%h", $time, Address, RAMout, exp_out);
        end
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        checks++;
        if (lit_act !== lit_exp) begin
          failures++;
          $display("FAIL %s got=%h want=%h", lit_name, lit_act, lit_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic lit(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    lit_name = n;
    lit_act  = act;
    lit_exp  = exp;
    lit_seq++;
    @(negedge clock);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    Address = a; data = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic rd_chk(input string n, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    Address = a; write = 1'b0;
`ifdef RAM_RDREG_EN
    tick();
`endif
    #1;
    lit(n, RAMout, exp);
  endtask

  // Counts edges after reset release until busy drops; bounded.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (busy !== 1'b0 && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    tick();
    do_reset();
    wait_ready(n);
    lit("clear_len", DW'(n), 32'd512);
    rd_chk("rst_a0",   9'd0,   32'h0);
    rd_chk("rst_a1",   9'd1,   32'h0);
    rd_chk("rst_a511", 9'd511, 32'h0);

    wr(9'd0, 32'hAA);
    wr(9'd1, 32'h55);
    rd_chk("rd_a1", 9'd1, 32'h55);
    rd_chk("rd_a0", 9'd0, 32'hAA);

    wr(9'd1, 32'h2A);
    rd_chk("ovw_a1", 9'd1, 32'h2A);
    rd_chk("ovw_a0", 9'd0, 32'hAA);

    // Writes while clearing must be dropped.
    do_reset();
    Address = 9'd5; data = 32'hDEADBEEF; write = 1'b1;
    repeat (10) tick();
    write = 1'b0;
    wait_ready(n);
    lit("busy_wr_len", DW'(n), 32'd502);
    rd_chk("busy_wr_a5", 9'd5, 32'h0);

    // Reset mid-clear restarts the full sequence.
    wr(9'd0, 32'h77);
    rd_chk("pre_a0", 9'd0, 32'h77);
    do_reset();
    repeat (200) tick();
    do_reset();
    wait_ready(n);
    lit("restart_len", DW'(n), 32'd512);
    rd_chk("restart_a0", 9'd0, 32'h0);

    wr(9'd511, 32'h12345678);
    rd_chk("top_a511", 9'd511, 32'h12345678);
    Address = 9'd3; data = 32'hCAFEF00D; write = 1'b1;
    do_reset();
    write = 1'b0;
    wait_ready(n);
    lit("rst2_len", DW'(n), 32'd512);
    rd_chk("rst2_a511", 9'd511, 32'h0);
    rd_chk("rst2_a3",   9'd3,   32'h0);

    // Mixed traffic checked by the model each cycle.
    for (int i = 0; i < 40; i++) begin
      Address = AW'(i * 37 % DEPTH);
      data    = DW'(32'h1000 + i);
      write   = (i % 3 != 2);
      tick();
    end
    write = 1'b0;

    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram.md
# ram

Single-port synchronous-write RAM, 512 × 32 by default, used as the processor's data/working memory. Writes occur on the rising clock edge when `write` is high. Reads return the word at `Address` combinationally, or one cycle later when the registered-read option is compiled in. After reset, a built-in sequencer zero-fills the array, so contents are always defined.

## Interface
- `ADDR_WIDTH`, 9: address bus width.
- `DATA_WIDTH`, 32: word width.
- `DEPTH`, 512: number of words; must be ≤ 2^ADDR_WIDTH.

Ports:
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous and active-high; starts the clear sequence.
- `Address`  in  ADDR_WIDTH  read/write word address.
- `write`  in  1  write enable; high at a rising edge stores `data` at `Address`.
- `data`  in  DATA_WIDTH  write data.
- `RAMout`  out  DATA_WIDTH  read data for `Address`.
- `busy`  out  1  high while reset or the clear sequence is active; user writes are ignored.

## Operation
- Storage: DEPTH words of DATA_WIDTH bits.
- Two-state controller, CLEAR and READY:
  - A rising edge with `reset`=1 enters CLEAR, sets the clear pointer to 0 and sets `busy`=1.
  - In CLEAR with `reset`=0, each edge writes 0 to mem[ptr] and increments ptr.
  - After the edge that writes word DEPTH-1, the controller moves to READY and `busy`=0.
- READY, write: at a rising edge with `write`=1 and `Address` < DEPTH, mem[Address] ← `data`.
- READY, read: `RAMout` = mem[Address], or 0 if `Address` ≥ DEPTH.
- Out-of-range writes (`Address` ≥ DEPTH) are ignored.
- Reset values:
  - `busy`=1 from the first reset edge.
  - `RAMout`=0 whenever `busy`=1.
  - All words read 0 after the clear completes.
- `reset` asserted during CLEAR restarts the sequence at ptr 0.
- `reset` asserted during a write cycle: the write is dropped.
- User writes while `busy`=1 are dropped, not queued.
- Read of the address being written in the same cycle:
  - Combinational mode: old data before the edge, new data after it.
  - Registered mode: the new data (write-first).
- Power-up state before the first reset is undefined; the system must apply reset.

## Timing
- Write latency: data is stored at the rising edge where `write`=1. In combinational mode it is visible on `RAMout` immediately after that edge.
- Read latency, combinational mode: 0 cycles, purely combinational from `Address` and memory contents.
- Read latency, registered mode: 1 cycle. `RAMout` updates at the edge following the `Address` change.
- Clear duration: `busy` is high during every cycle with `reset`=1, plus exactly DEPTH cycles after `reset` falls. For the defaults that is 512 cycles.
- `busy` is registered and deasserts on the edge that completes word DEPTH-1.

## Configuration
- `RAM_RDREG_EN` defined:
  - `RAMout` is a register loaded each rising edge with the read data for the current `Address`, with write-first bypass.
  - The register is synchronously reset to 0 and holds 0 while `busy`=1.
- `RAM_RDREG_EN` undefined:
  - `RAMout` is combinational, as described above.
  - No output register exists.

## Test plan
- Reset, then wait for `busy` to fall → `busy` high for exactly 512 cycles after reset release. Reads of addresses 0, 1 and 511 return 0x00000000.
- Write 0xAA at address 0, then 0x55 at address 1, then set `write`=0 → reading address 1 gives 0x55 and address 0 gives 0xAA. In registered mode each result appears one cycle after the address is applied.
- Overwrite address 1 with 0x2A, then read → 0x0000002A. Address 0 still reads 0xAA.
- Assert `write`=1 with `data`=0xDEADBEEF to address 5 while `busy`=1 → after the clear completes, address 5 reads 0.
- Assert `reset` for 1 cycle midway through the clear (ptr ≈ 200) → `busy` stays high for a further 512 cycles after release. Address 0 then reads 0.
- Write 0x12345678 at address 511, then reset again → after the clear completes, address 511 reads 0.
